// File: rtl/ups_axi4l_reg_slave.sv
// AXI4-Lite register slave for the UPS PL fabric.
// Holds NUM_REGS R/W control words plus a read-only status word at index NUM_REGS.
// The write and read channels are handled by independent FSMs, and each FSM
// allows one outstanding transaction.
//
// state  | meaning
// -------+-----------------------------------------------------------
// W_IDLE | awready high, waiting for a write address
// W_DATA | address latched, wready high, waiting for write data
// W_RESP | bvalid/bresp held until the master takes the response
// R_IDLE | arready high, waiting for a read address
// R_DATA | rdata/rresp/rvalid held until the master takes the data
module ups_axi4l_reg_slave #(
    parameter int          NUM_REGS  = 4,
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter logic [31:0] ERR_DATA  = 32'h0
) (
    input  logic                     fclk,
    input  logic                     rst,
    input  logic [31:0]              ca4l_awaddr,
    input  logic [2:0]               ca4l_awprot,
    input  logic                     ca4l_awvalid,
    output logic                     ca4l_awready,
    input  logic [31:0]              ca4l_wdata,
    input  logic [3:0]               ca4l_wstrb,
    input  logic                     ca4l_wvalid,
    output logic                     ca4l_wready,
    output logic [1:0]               ca4l_bresp,
    output logic                     ca4l_bvalid,
    input  logic                     ca4l_bready,
    input  logic [31:0]              ca4l_araddr,
    input  logic [2:0]               ca4l_arprot,
    input  logic                     ca4l_arvalid,
    output logic                     ca4l_arready,
    output logic [31:0]              ca4l_rdata,
    output logic [1:0]               ca4l_rresp,
    output logic                     ca4l_rvalid,
    input  logic                     ca4l_rready,
    input  logic [31:0]              sts_in,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    localparam logic [29:0] STS_IDX   = 30'(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [29:0]           aw_idx_q, aw_idx_d;
    logic [31:0]           regs_q [NUM_REGS];
    logic [31:0]           regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rd_dec_data;
    logic [1:0]            rd_dec_resp;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  unused_inputs;

    // The low address bits and the prot fields have no effect on the register map.
    assign unused_inputs = ^{ca4l_awprot, ca4l_arprot, ca4l_awaddr[1:0], ca4l_araddr[1:0]};

    assign aw_hs = ca4l_awvalid & awready_q;
    assign w_hs  = ca4l_wvalid  & wready_q;
    assign b_hs  = bvalid_q     & ca4l_bready;
    assign ar_hs = ca4l_arvalid & arready_q;
    assign r_hs  = rvalid_q     & ca4l_rready;

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_idx_q   <= '0;
            wr_pulse_q <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_idx_q   <= aw_idx_d;
            wr_pulse_q <= wr_pulse_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Write FSM next state, including the address latch and the byte-merged register update.
    always_comb begin
        w_state_d = w_state_q;
        aw_idx_d  = aw_idx_q;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_idx_d  = ca4l_awaddr[31:2];
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (aw_idx_q == 30'(i)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (ca4l_wstrb[b]) regs_d[i][8*b +: 8] = ca4l_wdata[8*b +: 8];
                            end
                        end
                    end
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel outputs are derived from the next state so they are registered alongside it.
    always_comb begin
        awready_d  = (w_state_d == W_IDLE);
        wready_d   = (w_state_d == W_DATA);
        bvalid_d   = (w_state_d == W_RESP);
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        if (w_state_q == W_DATA && w_hs) begin
            bresp_d = (aw_idx_q < STS_IDX) ? RESP_OKAY : RESP_SLV;
            for (int i = 0; i < NUM_REGS; i++) wr_pulse_d[i] = (aw_idx_q == 30'(i));
        end
    end

    // Read decode. This uses the pre-edge register values, so a write that hands off on the same edge is not seen.
    always_comb begin
        rd_dec_data = ERR_DATA;
        rd_dec_resp = RESP_SLV;
        if (ca4l_araddr[31:2] == STS_IDX) begin
            rd_dec_data = sts_in;
            rd_dec_resp = RESP_OKAY;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ca4l_araddr[31:2] == 30'(i)) begin
                rd_dec_data = regs_q[i];
                rd_dec_resp = RESP_OKAY;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) r_state_d = R_DATA;
        end else begin
            if (r_hs) r_state_d = R_IDLE;
        end
    end

    // Read channel outputs. rdata and rresp are captured once, at the AR handshake.
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (r_state_q == R_IDLE && ar_hs) begin
            rdata_d = rd_dec_data;
            rresp_d = rd_dec_resp;
        end
    end

    // Flatten the register bank onto reg_out.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_out[32*i +: 32] = regs_q[i];
    end

    assign ca4l_awready = awready_q;
    assign ca4l_wready  = wready_q;
    assign ca4l_bvalid  = bvalid_q;
    assign ca4l_bresp   = bresp_q;
    assign ca4l_arready = arready_q;
    assign ca4l_rvalid  = rvalid_q;
    assign ca4l_rdata   = rdata_q;
    assign ca4l_rresp   = rresp_q;
    assign wr_pulse     = wr_pulse_q;

endmodule

// File: tb/tb_ups_axi4l_reg_slave.sv
// Directed bench for ups_axi4l_reg_slave with the default four registers.
module tb_ups_axi4l_reg_slave;

    logic         fclk = 1'b0;
    logic         rst  = 1'b1;
    logic [31:0]  awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [31:0]  sts_in = '0;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    int n_checks = 0;
    int n_errors = 0;

    ups_axi4l_reg_slave dut (
        .fclk(fclk), .rst(rst),
        .ca4l_awaddr(awaddr), .ca4l_awprot(awprot), .ca4l_awvalid(awvalid), .ca4l_awready(awready),
        .ca4l_wdata(wdata), .ca4l_wstrb(wstrb), .ca4l_wvalid(wvalid), .ca4l_wready(wready),
        .ca4l_bresp(bresp), .ca4l_bvalid(bvalid), .ca4l_bready(bready),
        .ca4l_araddr(araddr), .ca4l_arprot(arprot), .ca4l_arvalid(arvalid), .ca4l_arready(arready),
        .ca4l_rdata(rdata), .ca4l_rresp(rresp), .ca4l_rvalid(rvalid), .ca4l_rready(rready),
        .sts_in(sts_in), .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int k);
        case (k)
            0: return awready;
            1: return wready;
            2: return bvalid;
            3: return arready;
            default: return rvalid;
        endcase
    endfunction

    // Wait (bounded) until the selected ready/valid is high at a falling edge.
    task automatic wait_for(input int k, input string tag);
        int n = 0;
        @(negedge fclk);
        while (!get_sig(k) && n < 50) begin
            @(negedge fclk);
            n++;
        end
        chk(tag, 128'(get_sig(k)), 128'd1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [3:0] p1, output logic [3:0] p2);
        awaddr = a;
        awvalid = 1'b1;
        wait_for(0, "aw_ready");
        @(posedge fclk); #1;
        awvalid = 1'b0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        wait_for(1, "w_ready");
        @(posedge fclk); #1;
        wvalid = 1'b0;
        p1 = wr_pulse;
        bready = 1'b1;
        wait_for(2, "b_valid");
        resp = bresp;
        @(posedge fclk); #1;
        bready = 1'b0;
        p2 = wr_pulse;
        chk("aw_reopen", 128'(awready), 128'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        araddr = a;
        arvalid = 1'b1;
        wait_for(3, "ar_ready");
        @(posedge fclk); #1;
        arvalid = 1'b0;
        chk("r_latency", 128'(rvalid), 128'd1);
        rready = 1'b1;
        wait_for(4, "r_valid");
        d = rdata;
        resp = rresp;
        @(posedge fclk); #1;
        rready = 1'b0;
        chk("ar_reopen", 128'(arready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  p1, p2;
        logic [31:0] d;

        repeat (3) @(posedge fclk);
        #1;
        chk("rst_awready", 128'(awready), 128'd0);
        chk("rst_arready", 128'(arready), 128'd0);
        chk("rst_bvalid", 128'(bvalid), 128'd0);
        chk("rst_rvalid", 128'(rvalid), 128'd0);
        chk("rst_reg_out", reg_out, 128'd0);
        chk("rst_pulse", 128'(wr_pulse), 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_awready_low", 128'(awready), 128'd0);
        @(posedge fclk); #1;
        chk("post_rst_awready", 128'(awready), 128'd1);
        chk("post_rst_arready", 128'(arready), 128'd1);

        // basic write/read of reg0
        axi_write(32'h0, 32'h0000_0002, 4'hF, resp, p1, p2);
        chk("w0_bresp", 128'(resp), 128'd0);
        chk("w0_pulse", 128'(p1), 128'h1);
        chk("w0_pulse_end", 128'(p2), 128'h0);
        chk("w0_reg_out", 128'(reg_out[31:0]), 128'h2);
        axi_read(32'h0, d, resp);
        chk("r0_data", 128'(d), 128'h2);
        chk("r0_rresp", 128'(resp), 128'd0);

        // reg1 retained across idle time
        axi_write(32'h4, 32'h0000_0800, 4'hF, resp, p1, p2);
        chk("w1_pulse", 128'(p1), 128'h2);
        repeat (200) @(posedge fclk);
        #1;
        axi_read(32'h4, d, resp);
        chk("r1_data", 128'(d), 128'h800);
        axi_read(32'h7, d, resp);
        chk("r1_alias", 128'(d), 128'h800);

        axi_write(32'h8, 32'h0000_0C00, 4'hF, resp, p1, p2);
        chk("w2_pulse", 128'(p1), 128'h4);
        chk("w2_reg_out", 128'(reg_out[95:64]), 128'hC00);

        // byte strobes
        axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, resp, p1, p2);
        axi_write(32'hC, 32'h0000_0000, 4'b0101, resp, p1, p2);
        chk("w3_strb_pulse", 128'(p1), 128'h8);
        axi_read(32'hC, d, resp);
        chk("r3_strb", 128'(d), 128'hFF00_FF00);
        chk("reg_out_all", reg_out, {32'hFF00_FF00, 32'h0000_0C00, 32'h0000_0800, 32'h0000_0002});

        // empty strobe: OKAY, pulse, no change
        axi_write(32'h4, 32'hFFFF_FFFF, 4'h0, resp, p1, p2);
        chk("strb0_bresp", 128'(resp), 128'd0);
        chk("strb0_pulse", 128'(p1), 128'h2);
        chk("strb0_reg", 128'(reg_out[63:32]), 128'h800);

        // status word and undecoded addresses
        sts_in = 32'hA5A5_5A5A;
        axi_read(32'h10, d, resp);
        chk("sts_data", 128'(d), 128'hA5A5_5A5A);
        chk("sts_rresp", 128'(resp), 128'd0);
        axi_write(32'h10, 32'h1234_5678, 4'hF, resp, p1, p2);
        chk("sts_w_bresp", 128'(resp), 128'd2);
        chk("sts_w_pulse", 128'(p1), 128'h0);
        chk("sts_w_noeffect", reg_out, {32'hFF00_FF00, 32'h0000_0C00, 32'h0000_0800, 32'h0000_0002});
        axi_read(32'h40, d, resp);
        chk("err_rdata", 128'(d), 128'h0);
        chk("err_rresp", 128'(resp), 128'd2);

        // write response back-pressure
        awaddr = 32'h10;
        awvalid = 1'b1;
        wait_for(0, "stall_aw_ready");
        @(posedge fclk); #1;
        awvalid = 1'b0;
        wdata = 32'h55;
        wstrb = 4'hF;
        wvalid = 1'b1;
        wait_for(1, "stall_w_ready");
        @(posedge fclk); #1;
        wvalid = 1'b0;
        awaddr = 32'h4;
        awvalid = 1'b1;
        repeat (10) begin
            @(negedge fclk);
            chk("stall_bvalid", 128'(bvalid), 128'd1);
            chk("stall_bresp", 128'(bresp), 128'd2);
            chk("stall_no_aw", 128'(awready), 128'd0);
        end
        bready = 1'b1;
        @(posedge fclk); #1;
        bready = 1'b0;
        awvalid = 1'b0;
        chk("stall_b_done", 128'(bvalid), 128'd0);

        // read data back-pressure; rdata must not follow sts_in once captured
        araddr = 32'h10;
        arvalid = 1'b1;
        wait_for(3, "stall_ar_ready");
        @(posedge fclk); #1;
        araddr = 32'h0;
        sts_in = 32'h1234_5678;
        repeat (10) begin
            @(negedge fclk);
            chk("stall_rvalid", 128'(rvalid), 128'd1);
            chk("stall_rdata", 128'(rdata), 128'hA5A5_5A5A);
            chk("stall_no_ar", 128'(arready), 128'd0);
        end
        rready = 1'b1;
        @(posedge fclk); #1;
        rready = 1'b0;
        arvalid = 1'b0;
        chk("stall_r_done", 128'(rvalid), 128'd0);

        // reset while waiting for write data
        awaddr = 32'h8;
        awvalid = 1'b1;
        wait_for(0, "rst_aw_ready");
        @(posedge fclk); #1;
        awvalid = 1'b0;
        wdata = 32'hDEAD;
        wstrb = 4'hF;
        wvalid = 1'b1;
        @(negedge fclk);
        chk("rst_in_wdata", 128'(wready), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        wvalid = 1'b0;
        chk("mid_rst_wready", 128'(wready), 128'd0);
        chk("mid_rst_awready", 128'(awready), 128'd0);
        chk("mid_rst_bvalid", 128'(bvalid), 128'd0);
        chk("mid_rst_arready", 128'(arready), 128'd0);
        chk("mid_rst_rvalid", 128'(rvalid), 128'd0);
        chk("mid_rst_regs", reg_out, 128'd0);
        @(posedge fclk); #1;
        rst = 1'b0;
        axi_write(32'h8, 32'h0000_1234, 4'hF, resp, p1, p2);
        chk("post_rst_bresp", 128'(resp), 128'd0);
        axi_read(32'h8, d, resp);
        chk("post_rst_r2", 128'(d), 128'h1234);
        axi_read(32'h0, d, resp);
        chk("post_rst_r0", 128'(d), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
